// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between instruction fetch and the MEM stage.
// The data port has priority, but a waiting fetch cannot lose more than MAX_D_STREAK grants in a row.
`default_nettype none

module unified_mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       streak_q, streak_d;
  logic                m_req_q, m_req_d;
  logic                m_we_q, m_we_d;
  logic [1:0]          m_size_q, m_size_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_out_q, if_out_d;
  logic                d_out_q, d_out_d;

  logic in_idle;
  logic streak_max;

  // Gating with reset keeps grants and stalls at 0 while reset is held.
  assign in_idle    = reset & (state_q == IDLE);
  assign streak_max = (streak_q == SW'(MAX_D_STREAK));
  assign if_gnt     = in_idle & if_req & (~d_req | streak_max);
  assign d_gnt      = in_idle & d_req & ~(if_req & streak_max);

  assign stall_if  = reset & ((if_req & ~if_gnt) | (if_out_q & ~if_rvalid_q));
  assign stall_mem = reset & ((d_req & ~d_gnt) | (d_out_q & ~d_rvalid_q));

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_size    = m_size_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_size_d    = m_size_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_out_d    = if_out_q & ~if_rvalid_q;
    d_out_d     = d_out_q & ~d_rvalid_q;

    case (state_q)
      IDLE: begin
        if (if_gnt) begin
          state_d   = I_ACC;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_size_d  = 2'b10;
          m_addr_d  = if_addr;
          m_wdata_d = '0;
          if_out_d  = 1'b1;
          streak_d  = '0;
        end else if (d_gnt) begin
          state_d   = D_ACC;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_size_d  = (d_size == 2'b11) ? 2'b10 : d_size;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          d_out_d   = 1'b1;
          if (!if_req) begin
            streak_d = '0;
          end else if (!streak_max) begin
            streak_d = streak_q + SW'(1);
          end
        end
      end
      I_ACC: begin
        if (m_ready) begin
          state_d     = IDLE;
          m_req_d     = 1'b0;
          m_we_d      = 1'b0;
          if_rvalid_d = 1'b1;
          if_rdata_d  = m_rdata;
        end
      end
      D_ACC: begin
        if (m_ready) begin
          state_d    = IDLE;
          m_req_d    = 1'b0;
          m_we_d     = 1'b0;
          d_rvalid_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_size_q    <= 2'b00;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_out_q    <= 1'b0;
      d_out_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_size_q    <= m_size_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_out_q    <= if_out_d;
      d_out_q     <= d_out_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sits between pc/IF logic, the MEM-stage load/store unit and the Memory block.
- Serialises accesses with a req/gnt/rvalid handshake, gives MEM-stage priority with a fetch anti-starvation limit, and generates per-port stall signals for the hazard unit.

Parameters:
ADDR_W, 10, byte address width presented to memory
DATA_W, 32, data width
MAX_D_STREAK, 4, max consecutive data grants while a fetch waits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  reset; one clock; reset is asynchronous and active-low
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held with d_* stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_size  in  2  00 byte, 01 half, 10 word
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid or store complete
d_rdata  out  DATA_W  load data
m_req  out  1  memory access active
m_we  out  1  memory write enable
m_size  out  2  access size to memory
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_ready  in  1  memory completes access this cycle
m_rdata  in  DATA_W  memory read data, valid when m_ready
stall_if  out  1  fetch is waiting
stall_mem  out  1  data access is waiting

Behaviour:
- Reset: every output 0, FSM = IDLE, streak counter = 0, owner/outstanding flags cleared.
- FSM states: IDLE, I_ACC, D_ACC.
- IDLE grant rule (combinational gnt, same cycle as req):
  - Only d_req: d_gnt = 1.
  - Only if_req: if_gnt = 1.
  - Both requesting: d_gnt = 1, unless streak == MAX_D_STREAK, in which case if_gnt = 1.
  - At most one gnt per cycle; gnt is never asserted outside IDLE.
- On the grant edge: register m_addr, m_we (0 for fetch), m_size (10 for fetch), and m_wdata; set m_req = 1; move to I_ACC or D_ACC.
- d_size = 11 is forwarded as 10. Misaligned addresses pass through unchanged.
- ACC states:
  - m_req and all m_* outputs stay constant until m_ready = 1 is sampled.
  - On that edge: m_req = 0, m_we = 0, state = IDLE.
  - For reads, latch m_rdata into if_rdata or d_rdata; the matching rvalid pulses high for exactly the next cycle.
  - For stores, d_rvalid pulses and d_rdata holds its previous value.
- Timing:
  - Minimum latency is gnt at cycle 0, m_req at cycle 1, rvalid at cycle 2 with m_ready tied high.
  - A new grant is possible in the rvalid cycle (back-to-back, one access per 2 cycles).
- m_ready is ignored in IDLE.
- Streak counter:
  - Increments on a d_gnt when if_req = 1 in the same cycle, saturating at MAX_D_STREAK.
  - Clears on any if_gnt, or on a d_gnt with if_req = 0.
- Stall outputs:
  - stall_if = (if_req & ~if_gnt) | fetch outstanding without if_rvalid.
  - stall_mem is defined the same way for the data port.
  - "Outstanding" is set at gnt and cleared by the matching rvalid.
- Rdata outputs hold their last value between pulses.
- Asynchronous reset mid-access:
  - m_req drops immediately.
  - The outstanding access is discarded; no rvalid is produced after release.
  - The first cycle after release is IDLE.

Test Plan:
1. Reset held low, random inputs toggling -> all outputs 0; after release with no requests, m_req stays 0.
2. if_req, if_addr = 0x010, m_ready = 1, m_rdata = 0x00500093 -> if_gnt at cycle 0; m_req = 1 and m_addr = 0x010 at cycle 1; if_rvalid = 1 and if_rdata = 0x00500093 at cycle 2.
3. if_req and d_req (load, addr 0x104, size 10) asserted together -> d_gnt first, stall_if = 1; if_gnt in the IDLE cycle after d_rvalid.
4. d_req and if_req held high continuously -> exactly 4 consecutive d_gnt, then if_gnt, then the streak restarts.
5. Store d_addr = 0x200, d_wdata = 0xDEADBEEF, size 01, m_ready low for 3 cycles -> m_req/m_we/m_addr/m_wdata/m_size = 1/1/0x200/0xDEADBEEF/01, stable for 4 cycles; stall_mem = 1; d_rvalid exactly one cycle after m_ready.
6. reset pulled low during D_ACC with m_ready = 0 -> m_req = 0 asynchronously; after release no d_rvalid, state IDLE, and a new if_req is granted immediately.
